// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//   Groups the push-button signals of the button conditioner.
//   Signals:
//     button_raw  raw, bouncy pad level (1 = pressed), driven by the pad side
//     button      one-cycle step pulse toward the LED colour stage
//     level       debounced button level
//   Modports:
//     master  pad / consumer side: drives button_raw, observes button and level
//     slave   conditioner side: samples button_raw, drives button and level
// -----------------------------------------------------------------------------
interface button_conditioner_if;
    logic button_raw;
    logic button;
    logic level;

    modport master (output button_raw, input button, input level);
    modport slave  (input button_raw, output button, output level);
endinterface

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Turns a bouncy push-button pad input into a clean one-cycle step pulse for
//   the LED colour stage, and exports the debounced level.
//   Chain: 2-flop synchroniser -> debounce counter -> press/auto-repeat FSM.
//
//   Ports:
//     clk   in   single clock, all state updates on posedge
//     rst   in   synchronous, active-high reset
//     bus   slave modport of button_conditioner_if
//             button_raw in  : asynchronous pad input, 1 = pressed
//             button     out : registered step pulse, one cycle per step
//             level      out : registered debounced level
//
//   Configuration macro: AUTO_REPEAT_EN
//     defined   : press pulse, first repeat HOLD_CYCLES later, then one
//                 every REPEAT_CYCLES while held.
//     undefined : exactly one pulse per debounced press; the REPEAT state and
//                 the repeat counter do not exist.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int HOLD_CYCLES     = 32,
    parameter int REPEAT_CYCLES   = 8,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    button_conditioner_if.slave   bus
);

    // Reject configurations the counters cannot represent.
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        DEBOUNCE_CYCLES >= (2 ** CNT_W) || HOLD_CYCLES >= (2 ** CNT_W) ||
        REPEAT_CYCLES >= (2 ** CNT_W)) begin : g_bad_cfg
        $error("button_conditioner: invalid *_CYCLES / CNT_W combination");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rcnt;
`else
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

    logic             sync1, sync2;
    logic [CNT_W-1:0] dcnt;
    logic             level_q;
    logic             button_q;
    state_t           state;

    // The debounced level flips on this edge; the FSM reacts on the same edge
    // so the press pulse lines up with the level rise.
    logic flip, rise, fall;
    assign flip = (sync2 != level_q) && (dcnt == DEB_LAST);
    assign rise = flip && !level_q;
    assign fall = flip &&  level_q;

    // Synchroniser and debounce counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            dcnt    <= '0;
            level_q <= 1'b0;
        end else begin
            sync1 <= bus.button_raw;
            sync2 <= sync1;
            if (sync2 == level_q) begin
                dcnt <= '0;
            end else if (flip) begin
                level_q <= ~level_q;
                dcnt    <= '0;
            end else begin
                dcnt <= dcnt + CNT_W'(1);
            end
        end
    end

    // Press / auto-repeat FSM. A level fall always takes priority over a
    // counter expiry, so release never emits a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            button_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt     <= '0;
`endif
        end else begin
            button_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        button_q <= 1'b1;
                        state    <= HOLD;
`ifdef AUTO_REPEAT_EN
                        rcnt     <= '0;
`endif
                    end
                end
`ifdef AUTO_REPEAT_EN
                HOLD: begin
                    if (fall) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == HOLD_LAST) begin
                        button_q <= 1'b1;
                        rcnt     <= '0;
                        state    <= REPEAT;
                    end else begin
                        rcnt <= rcnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == REP_LAST) begin
                        button_q <= 1'b1;
                        rcnt     <= '0;
                    end else begin
                        rcnt <= rcnt + CNT_W'(1);
                    end
                end
`else
                HOLD: begin
                    if (fall) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.button = button_q;
    assign bus.level  = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with default parameters. Outputs are
//   sampled 1 time unit after each rising edge; inputs change at that point so
//   they are seen by the following edge. Expected pulse positions are written
//   as offsets from the press pulse P. Honours AUTO_REPEAT_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

`ifdef AUTO_REPEAT_EN
    localparam bit AUTO     = 1'b1;
    localparam int HOLD_WIN = 60;
`else
    localparam bit AUTO     = 1'b0;
    localparam int HOLD_WIN = 100;
`endif

    button_conditioner_if bif ();

    button_conditioner dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected button value k cycles after the press pulse while held.
    function automatic int rep_pulse(input int k);
        if (!AUTO) return 0;
        return (k >= 32 && (k - 32) % 8 == 0) ? 1 : 0;
    endfunction

    // button_raw already 1 (or about to be sampled as 1 on the next edge E):
    // level and pulse appear together on edge E+9, i.e. the 10th tick.
    task automatic press_to_pulse(input string tag);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk({tag, "_press_btn"}, int'(bif.button), (k == 10) ? 1 : 0);
            chk({tag, "_press_lvl"}, int'(bif.level),  (k == 10) ? 1 : 0);
        end
    endtask

    // Drop button_raw; level falls on the 10th tick. Optionally check no pulse.
    task automatic release_lvl(input string tag, input bit check_btn);
        bif.button_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk({tag, "_rel_lvl"}, int'(bif.level), (k == 10) ? 0 : 1);
            if (check_btn) chk({tag, "_rel_btn"}, int'(bif.button), 0);
        end
    endtask

    initial begin
        // 1. reset with the button held, then press after reset
        rst = 1'b1;
        bif.button_raw = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1_rst_lvl", int'(bif.level),  0);
            chk("t1_rst_btn", int'(bif.button), 0);
        end
        rst = 1'b0;
        press_to_pulse("t1");
        release_lvl("t1", 1'b1);

        // 2. short 5-cycle glitch never flips level
        bif.button_raw = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (k == 5) bif.button_raw = 1'b0;
            tick();
            chk("t2_lvl", int'(bif.level),  0);
            chk("t2_btn", int'(bif.button), 0);
        end

        // 3. bounce every 3 cycles for 30 cycles, then settle high
        for (int seg = 0; seg < 10; seg++) begin
            bif.button_raw = (seg % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("t3_bnc_lvl", int'(bif.level),  0);
                chk("t3_bnc_btn", int'(bif.button), 0);
            end
        end
        bif.button_raw = 1'b1;
        press_to_pulse("t3");
        release_lvl("t3", 1'b1);

        // 4. long hold: repeats at P+32, +40, +48, +56 only with auto-repeat
        bif.button_raw = 1'b1;
        press_to_pulse("t4");
        for (int k = 1; k <= HOLD_WIN; k++) begin
            tick();
            chk("t4_hold_btn", int'(bif.button), rep_pulse(k));
        end
        release_lvl("t4", 1'b0);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("t4_idle_btn", int'(bif.button), 0);
        end

        // 5. release after P+20: level drops at P+30, no pulse through P+60
        bif.button_raw = 1'b1;
        press_to_pulse("t5");
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("t5_hold_btn", int'(bif.button), 0);
        end
        bif.button_raw = 1'b0;
        for (int k = 21; k <= 60; k++) begin
            tick();
            chk("t5_rel_btn", int'(bif.button), 0);
            chk("t5_rel_lvl", int'(bif.level), (k >= 30) ? 0 : 1);
        end

        // 6. reset at P+35 aborts; new press 9 edges after rst deasserts
        bif.button_raw = 1'b1;
        press_to_pulse("t6");
        for (int k = 1; k <= 34; k++) begin
            tick();
            chk("t6_hold_btn", int'(bif.button), rep_pulse(k));
        end
        rst = 1'b1;
        tick();
        chk("t6_rst_btn", int'(bif.button), 0);
        chk("t6_rst_lvl", int'(bif.level),  0);
        rst = 1'b0;
        press_to_pulse("t6b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
